// File: rtl/quadrature_decoder_if.sv
// Encoder pins, preload/clear controls and decoded position outputs of the
// quadrature decoder, bundled for the decoder (slave) and its driver (master).
interface quadrature_decoder_if #(
    parameter int data_width = 4
);
    logic                  enc_a;
    logic                  enc_b;
    logic                  load;
    logic [data_width-1:0] load_value;
    logic                  clear_err;
    logic [data_width-1:0] count;
    logic                  dir;
    logic                  step;
    logic                  err;

    modport master (
        output enc_a, enc_b, load, load_value, clear_err,
        input  count, dir, step, err
    );

    modport slave (
        input  enc_a, enc_b, load, load_value, clear_err,
        output count, dir, step, err
    );
endinterface

// File: rtl/quadrature_decoder.sv
// Quadrature A/B decoder: per-phase synchronisers, Gray-step decode, preloadable
// wrap-around position counter, and sticky illegal-transition flag.
module quadrature_decoder_sync #(
    parameter int stages = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [stages-1:0] ff;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ff <= '0;
        else        ff <= {ff[stages-2:0], d};
    end

    assign q = ff[stages-1];
endmodule

module quadrature_decoder #(
    parameter int data_width  = 4,
    parameter int sync_stages = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    quadrature_decoder_if.slave  bus
);
    localparam logic [data_width-1:0] ONE = 1;

    logic [1:0]             pins;
    logic [1:0]             s;
    logic [1:0]             prev;
    logic [sync_stages:0]   prime_pipe;
    logic                   primed;
    logic [1:0]             delta;
    logic                   up;
    logic                   down;
    logic                   illegal;

    logic [data_width-1:0]  count_q, count_d;
    logic                   dir_q, dir_d;
    logic                   step_q, step_d;
    logic                   err_q, err_d;

    // Gray code mapped onto a 0..3 ring position so a step is a +/-1 difference.
    function automatic logic [1:0] ring_pos(input logic [1:0] ab);
        case (ab)
            2'b00:   ring_pos = 2'd0;
            2'b10:   ring_pos = 2'd1;
            2'b11:   ring_pos = 2'd2;
            default: ring_pos = 2'd3;
        endcase
    endfunction

    assign pins = {bus.enc_a, bus.enc_b};

    for (genvar i = 0; i < 2; i++) begin : g_sync
        quadrature_decoder_sync #(.stages(sync_stages)) u_sync (
            .clk   (clk),
            .reset (reset),
            .d     (pins[i]),
            .q     (s[i])
        );
    end

    // Ones shift in from reset; decode starts once they reach the top bit,
    // which lets the synchronisers and prev settle on the parked pin state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prime_pipe <= '0;
            prev       <= 2'b00;
        end else begin
            prime_pipe <= {prime_pipe[sync_stages-1:0], 1'b1};
            prev       <= s;
        end
    end

    assign primed  = prime_pipe[sync_stages];
    assign delta   = ring_pos(s) - ring_pos(prev);
    assign up      = primed && (delta == 2'd1);
    assign down    = primed && (delta == 2'd3);
    assign illegal = primed && (delta == 2'd2);

    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        err_d   = err_q;

        if (illegal)        err_d = 1'b1;
        else if (bus.clear_err) err_d = 1'b0;

        // Load discards any step decoded in the same cycle.
        if (bus.load) begin
            count_d = bus.load_value;
        end else if (up) begin
            count_d = count_q + ONE;
            dir_d   = 1'b1;
            step_d  = 1'b1;
        end else if (down) begin
            count_d = count_q - ONE;
            dir_d   = 1'b0;
            step_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            err_q   <= err_d;
        end
    end

    assign bus.count = count_q;
    assign bus.dir   = dir_q;
    assign bus.step  = step_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed bench for quadrature_decoder: a vector table of steady-state pin
// moves plus hand-timed sequences for latency, load collision, err and reset.
module tb_quadrature_decoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    quadrature_decoder_if #(.data_width(4)) bus ();

    quadrature_decoder #(.data_width(4), .sync_stages(2)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] ab;
        logic       ld;
        logic [3:0] lv;
        logic       clr;
        logic [3:0] cnt;
        logic       dir;
        int         steps;
        logic       err;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] ab, input logic ld, input logic [3:0] lv,
                                input logic clr, input logic [3:0] cnt, input logic dir,
                                input int steps, input logic err);
        vec_t v;
        v.ab = ab; v.ld = ld; v.lv = lv; v.clr = clr;
        v.cnt = cnt; v.dir = dir; v.steps = steps; v.err = err;
        return v;
    endfunction

    // Drive one table row at a negedge, hold 5 cycles, count step pulses.
    task automatic apply_vec(input int idx);
        int n = 0;
        {bus.enc_a, bus.enc_b} = vecs[idx].ab;
        bus.load       = vecs[idx].ld;
        bus.load_value = vecs[idx].lv;
        bus.clear_err  = vecs[idx].clr;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.step) n++;
            bus.load      = 1'b0;
            bus.clear_err = 1'b0;
        end
        check($sformatf("v%0d count", idx), bus.count, vecs[idx].cnt);
        check($sformatf("v%0d dir", idx), bus.dir, vecs[idx].dir);
        check($sformatf("v%0d steps", idx), n, vecs[idx].steps);
        check($sformatf("v%0d err", idx), bus.err, vecs[idx].err);
    endtask

    // Pin change at a negedge; strobes land on the decode edge (third posedge).
    task automatic edge_seq(input string name, input logic [1:0] ab, input logic ld,
                            input logic [3:0] lv, input logic clr, input logic exp_step,
                            input logic [3:0] exp_cnt, input logic exp_dir, input logic exp_err);
        {bus.enc_a, bus.enc_b} = ab;
        @(posedge clk); @(negedge clk);
        check({name, " step@1"}, bus.step, 0);
        @(posedge clk); @(negedge clk);
        check({name, " step@2"}, bus.step, 0);
        bus.load       = ld;
        bus.load_value = lv;
        bus.clear_err  = clr;
        @(posedge clk); @(negedge clk);
        bus.load      = 1'b0;
        bus.clear_err = 1'b0;
        check({name, " step@3"}, bus.step, exp_step);
        check({name, " count"}, bus.count, exp_cnt);
        check({name, " dir"}, bus.dir, exp_dir);
        check({name, " err"}, bus.err, exp_err);
        @(posedge clk); @(negedge clk);
        check({name, " step@4"}, bus.step, 0);
    endtask

    initial begin
        vecs[0]  = mk(2'b01, 1'b0, 4'h0, 1'b0, 4'h1, 1'b1, 1, 1'b0);
        vecs[1]  = mk(2'b00, 1'b0, 4'h0, 1'b0, 4'h2, 1'b1, 1, 1'b0);
        vecs[2]  = mk(2'b10, 1'b0, 4'h0, 1'b0, 4'h3, 1'b1, 1, 1'b0);
        vecs[3]  = mk(2'b11, 1'b0, 4'h0, 1'b0, 4'h4, 1'b1, 1, 1'b0);
        vecs[4]  = mk(2'b01, 1'b0, 4'h0, 1'b0, 4'h5, 1'b1, 1, 1'b0);
        vecs[5]  = mk(2'b00, 1'b0, 4'h0, 1'b0, 4'h6, 1'b1, 1, 1'b0);
        vecs[6]  = mk(2'b00, 1'b1, 4'hF, 1'b0, 4'hF, 1'b1, 0, 1'b0);
        vecs[7]  = mk(2'b10, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1, 1'b0);
        vecs[8]  = mk(2'b00, 1'b0, 4'h0, 1'b0, 4'hF, 1'b0, 1, 1'b0);
        vecs[9]  = mk(2'b01, 1'b0, 4'h0, 1'b0, 4'hE, 1'b0, 1, 1'b0);
        vecs[10] = mk(2'b10, 1'b0, 4'h0, 1'b0, 4'hE, 1'b0, 0, 1'b1);
        vecs[11] = mk(2'b10, 1'b0, 4'h0, 1'b1, 4'hE, 1'b0, 0, 1'b0);
        vecs[12] = mk(2'b00, 1'b0, 4'h0, 1'b0, 4'hD, 1'b0, 1, 1'b0);
        vecs[13] = mk(2'b11, 1'b0, 4'h0, 1'b0, 4'hD, 1'b0, 0, 1'b1);
        vecs[14] = mk(2'b11, 1'b0, 4'h0, 1'b1, 4'hD, 1'b0, 0, 1'b0);

        bus.enc_a = 1'b1; bus.enc_b = 1'b1;
        bus.load = 1'b0; bus.load_value = 4'h0; bus.clear_err = 1'b0;

        // Reset with pins parked at 11, then priming must stay silent.
        #12;
        check("rst count", bus.count, 0);
        check("rst dir", bus.dir, 0);
        check("rst step", bus.step, 0);
        check("rst err", bus.err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("prime%0d step", i), bus.step, 0);
            check($sformatf("prime%0d err", i), bus.err, 0);
        end
        check("prime count", bus.count, 0);

        for (int i = 0; i < 15; i++) apply_vec(i);

        // Pins now 11, count D, dir 0, err 0.
        edge_seq("lat down", 2'b10, 1'b0, 4'h0, 1'b0, 1'b1, 4'hC, 1'b0, 1'b0);
        edge_seq("load coll", 2'b11, 1'b1, 4'h5, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("load coll hold", bus.count, 5);
        edge_seq("illegal", 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, 4'h5, 1'b0, 1'b1);
        edge_seq("clr+illegal", 2'b11, 1'b0, 4'h0, 1'b1, 1'b0, 4'h5, 1'b0, 1'b1);
        bus.clear_err = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.clear_err = 1'b0;
        check("clr err", bus.err, 0);

        // Count up to 7, then async reset between edges.
        edge_seq("up to 6", 2'b01, 1'b1, 4'h6, 1'b0, 1'b0, 4'h6, 1'b0, 1'b0);
        edge_seq("up to 7", 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 4'h7, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("async rst count", bus.count, 0);
        check("async rst dir", bus.dir, 0);
        @(negedge clk);
        {bus.enc_a, bus.enc_b} = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("reprime%0d step", i), bus.step, 0);
            check($sformatf("reprime%0d err", i), bus.err, 0);
        end
        edge_seq("after rst", 2'b01, 1'b0, 4'h0, 1'b0, 1'b1, 4'h1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
